// File: rtl/axi_eth_tx_arbiter.sv
// axi_eth_tx_arbiter: two-source Ethernet TX arbiter emitting a control frame then the granted data frame; define AXI_ETH_TX_ARB_PRIO_EN for strict s0 priority instead of round-robin
module axi_eth_tx_arbiter #(
  parameter int          DATA_WIDTH = 32,
  parameter int          TXC_WORDS  = 6,
  parameter logic [31:0] TXC_FLAG   = 32'hA000_0000
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s0_axis_txd_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_txd_tkeep,
  input  logic                    s0_axis_txd_tlast,
  input  logic                    s0_axis_txd_tvalid,
  output logic                    s0_axis_txd_tready,
  input  logic [DATA_WIDTH-1:0]   s1_axis_txd_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_txd_tkeep,
  input  logic                    s1_axis_txd_tlast,
  input  logic                    s1_axis_txd_tvalid,
  output logic                    s1_axis_txd_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_txc_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_txc_tkeep,
  output logic                    m_axis_txc_tlast,
  output logic                    m_axis_txc_tvalid,
  input  logic                    m_axis_txc_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_txd_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_txd_tkeep,
  output logic                    m_axis_txd_tlast,
  output logic                    m_axis_txd_tvalid,
  input  logic                    m_axis_txd_tready,
  output logic                    busy,
  output logic                    grant,
  output logic [15:0]             frame_cnt
);
  typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;
  state_t                  state, state_nxt;
  logic [3:0]              beat;
  logic                    last_grant, pick, req, ctrl_hs, ctrl_end, data_end;
  logic                    src_tvalid, src_tlast;
  logic [DATA_WIDTH-1:0]   src_tdata;
  logic [DATA_WIDTH/8-1:0] src_tkeep;
  assign req = s0_axis_txd_tvalid | s1_axis_txd_tvalid;
`ifdef AXI_ETH_TX_ARB_PRIO_EN
  assign pick = !s0_axis_txd_tvalid;
`else
  assign pick = (s0_axis_txd_tvalid && s1_axis_txd_tvalid) ? !last_grant : s1_axis_txd_tvalid;
`endif
  // Select the source owning the current frame
  always_comb begin
    src_tdata  = grant ? s1_axis_txd_tdata  : s0_axis_txd_tdata;
    src_tkeep  = grant ? s1_axis_txd_tkeep  : s0_axis_txd_tkeep;
    src_tlast  = grant ? s1_axis_txd_tlast  : s0_axis_txd_tlast;
    src_tvalid = grant ? s1_axis_txd_tvalid : s0_axis_txd_tvalid;
  end
  // Next-state decode and all stream outputs; data path is a pure pass-through in DATA
  always_comb begin
    ctrl_hs            = state == CTRL && m_axis_txc_tready;
    ctrl_end           = ctrl_hs && beat == 4'(TXC_WORDS - 1);
    data_end           = state == DATA && src_tvalid && src_tlast && m_axis_txd_tready;
    state_nxt          = state == IDLE ? (req ? CTRL : IDLE) :
                         state == CTRL ? (ctrl_end ? DATA : CTRL) : (data_end ? IDLE : DATA);
    busy               = state != IDLE;
    m_axis_txc_tvalid  = state == CTRL;
    m_axis_txc_tdata   = m_axis_txc_tvalid && beat == 4'd0 ? DATA_WIDTH'(TXC_FLAG) : '0;
    m_axis_txc_tkeep   = {(DATA_WIDTH/8){m_axis_txc_tvalid}};
    m_axis_txc_tlast   = m_axis_txc_tvalid && beat == 4'(TXC_WORDS - 1);
    m_axis_txd_tvalid  = state == DATA && src_tvalid;
    m_axis_txd_tlast   = state == DATA && src_tlast;
    m_axis_txd_tdata   = state == DATA ? src_tdata : '0;
    m_axis_txd_tkeep   = state == DATA ? src_tkeep : '0;
    s0_axis_txd_tready = state == DATA && !grant && m_axis_txd_tready;
    s1_axis_txd_tready = state == DATA && grant && m_axis_txd_tready;
  end
  // State register
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nxt;
  // Control beat index, advanced only on accepted beats
  always_ff @(posedge aclk or posedge areset)
    if (areset) beat <= '0;
    else if (ctrl_end) beat <= '0;
    else if (ctrl_hs) beat <= beat + 4'd1;
  // Owner of the frame, decided once in IDLE and frozen until the frame ends
  always_ff @(posedge aclk or posedge areset)
    if (areset) grant <= 1'b0;
    else if (state == IDLE && req) grant <= pick;
  // Round-robin history and completed-frame count, updated on the final data beat
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      last_grant <= 1'b1;
      frame_cnt  <= '0;
    end else if (data_end) begin
      last_grant <= grant;
      frame_cnt  <= frame_cnt + 16'd1;
    end
endmodule
